fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_unit.sv | 79 +++++++
 tb/tb_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0]  RESET_PC_DEFAULT = 32'h8000_0000;
    localparam int unsigned  INSTR_W          = 32;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular instruction buffer with flush; push and pop may coincide at any occupancy.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter type         entry_t = fetch_entry_t,
    localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output entry_t        head
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // When full, a simultaneous push writes the slot the head is vacating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, tracks one in-flight imem read and buffers returned words for decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = CW + 1;

    logic [31:0]   pc;
    logic          req_q;
    logic [31:0]   req_pc_q;
    logic [CW-1:0] count;
    logic [OW-1:0] occupancy;
    logic          pop;
    logic          push;
    logic          issue;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    assign pop  = out_valid && out_ready;
    assign push = req_q && !redirect_valid;

    // Slots committed after this cycle: buffered + returning - leaving.
    assign occupancy = OW'(count) + OW'(req_q) - OW'(pop);
    assign issue     = !redirect_valid && (occupancy < OW'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            req_q    <= 1'b0;
            req_pc_q <= '0;
        end else if (redirect_valid) begin
            pc    <= {redirect_pc[31:2], 2'b00};
            req_q <= 1'b0;
        end else if (issue) begin
            pc       <= pc + 32'd4;
            req_q    <= 1'b1;
            req_pc_q <= pc;
        end else begin
            req_q <= 1'b0;
        end
    end

    assign push_entry = '{pc: req_pc_q, instr: imem_data};

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head      (head)
    );

    assign imem_addr = pc;
    assign out_valid = (count != '0);
    assign out_instr = head.instr;
    assign out_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle registered instruction memory model.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RPC = RESET_PC_DEFAULT;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    fetch_unit #(
        .RESET_PC (RPC),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    always @(posedge clk) imem_data <= word(imem_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle c0, the first cycle after reset release.
    task automatic do_reset(input logic rdy);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = rdy;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        step();
        step();
        n_cmp++;
        if (imem_addr !== RPC) begin
            n_bad++; $display("FAIL reset_addr: got %h expected %h", imem_addr, RPC);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        n_cmp++;
        if ({out_pc, out_instr} !== 64'h0) begin
            n_bad++; $display("FAIL reset_payload: got %h/%h expected 0/0", out_pc, out_instr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        do_reset(1'b1);
        n_cmp++;
        if (imem_addr !== RPC) begin
            n_bad++; $display("FAIL stream_c0_addr: got %h expected %h", imem_addr, RPC);
        end
        for (int c = 0; c < 8; c++) begin
            n_cmp++;
            if (out_valid !== (c >= 2)) begin
                n_bad++; $display("FAIL stream_valid c%0d: got %b expected %b", c, out_valid, c >= 2);
            end
            if (c >= 2) begin
                exp = RPC + 32'(4 * (c - 2));
                n_cmp++;
                if (out_pc !== exp || out_instr !== word(exp)) begin
                    n_bad++; $display("FAIL stream_data c%0d: got %h/%h expected %h/%h",
                                      c, out_pc, out_instr, exp, word(exp));
                end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        do_reset(1'b0);
        for (int c = 0; c < 12; c++) begin
            if (c >= 2) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_pc !== RPC || out_instr !== word(RPC)) begin
                    n_bad++; $display("FAIL bp_hold c%0d: got %b/%h/%h expected 1/%h/%h",
                                      c, out_valid, out_pc, out_instr, RPC, word(RPC));
                end
            end
            step();
        end
        n_cmp++;
        if (imem_addr !== RPC + 32'd8) begin
            n_bad++; $display("FAIL bp_frozen_addr: got %h expected %h", imem_addr, RPC + 32'd8);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp = RPC + 32'(4 * k);
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc !== exp || out_instr !== word(exp)) begin
                n_bad++; $display("FAIL bp_drain k%0d: got %b/%h/%h expected 1/%h/%h",
                                  k, out_valid, out_pc, out_instr, exp, word(exp));
            end
            step();
        end
    endtask

    task automatic test_redirect_inflight();
        logic [31:0] exp;
        do_reset(1'b0);
        step();
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== RPC) begin
            n_bad++; $display("FAIL rdi_pre: got %b/%h expected 1/%h", out_valid, out_pc, RPC);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0043;
        step();
        redirect_valid = 1'b0;
        n_cmp++;
        if (imem_addr !== 32'h8000_0040) begin
            n_bad++; $display("FAIL rdi_addr: got %h expected 80000040", imem_addr);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL rdi_t1_valid: got %b expected 0", out_valid);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL rdi_t2_valid: got %b expected 0", out_valid);
        end
        step();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp = 32'h8000_0040 + 32'(4 * k);
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc !== exp || out_instr !== word(exp)) begin
                n_bad++; $display("FAIL rdi_new k%0d: got %b/%h/%h expected 1/%h/%h",
                                  k, out_valid, out_pc, out_instr, exp, word(exp));
            end
            step();
        end
    endtask

    task automatic test_redirect_pop();
        do_reset(1'b1);
        repeat (4) step();
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== RPC + 32'd8) begin
            n_bad++; $display("FAIL rdp_popped: got %b/%h expected 1/%h", out_valid, out_pc, RPC + 32'd8);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        step();
        redirect_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h8000_0100) begin
            n_bad++; $display("FAIL rdp_t1: got %b/%h expected 0/80000100", out_valid, imem_addr);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL rdp_t2_valid: got %b expected 0", out_valid);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 32'h8000_0100) begin
            n_bad++; $display("FAIL rdp_t3: got %b/%h expected 1/80000100", out_valid, out_pc);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 32'h8000_0104) begin
            n_bad++; $display("FAIL rdp_t4: got %b/%h expected 1/80000104", out_valid, out_pc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        do_reset(1'b1);
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            exp = 32'hFFFF_FFF8 + 32'(4 * k);
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc !== exp || out_instr !== word(exp)) begin
                n_bad++; $display("FAIL wrap k%0d: got %b/%h/%h expected 1/%h/%h",
                                  k, out_valid, out_pc, out_instr, exp, word(exp));
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        repeat (4) step();
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++; $display("FAIL rstm_pre_valid: got %b expected 1", out_valid);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || imem_addr !== RPC) begin
            n_bad++; $display("FAIL rstm_async: got %b/%h/%h expected 0/00000000/%h",
                              out_valid, out_pc, imem_addr, RPC);
        end
        step();
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== RPC || out_instr !== word(RPC)) begin
            n_bad++; $display("FAIL rstm_first: got %b/%h/%h expected 1/%h/%h",
                              out_valid, out_pc, out_instr, RPC, word(RPC));
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== RPC + 32'd4) begin
            n_bad++; $display("FAIL rstm_second: got %b/%h expected 1/%h", out_valid, out_pc, RPC + 32'd4);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_pop();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
